// File: rtl/v6_pulse_generator.sv
// Synthetic detector-pulse source: linear rise, exponential decay on a fixed baseline.
// Feeds the trapezoidal shaper in place of an ADC; supports pile-up and periodic auto-trigger.
module v6_pulse_generator #(
  parameter int SIZE_ADC_DATA = 12,
  parameter int BASELINE      = 100,
  parameter int RISE_SHIFT    = 2,
  parameter int DECAY_SHIFT   = 4,
  parameter int FRAC          = 8,
  parameter int PERIOD        = 1000
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     trigger,
  input  logic [SIZE_ADC_DATA-1:0] amplitude,
  input  logic                     auto_en,
  output logic [SIZE_ADC_DATA-1:0] output_data,
  output logic                     busy,
  output logic                     pulse_start,
  output logic                     dropped
);

  localparam int W  = SIZE_ADC_DATA + FRAC;
  localparam int CW = $clog2(PERIOD);

  localparam logic [W-1:0]             ACC_MAX   = {{SIZE_ADC_DATA{1'b1}}, {FRAC{1'b0}}};
  localparam logic [RISE_SHIFT:0]      RISE_LAST = (RISE_SHIFT+1)'(2**RISE_SHIFT - 1);
  localparam logic [CW-1:0]            PER_LAST  = CW'(PERIOD - 1);
  localparam logic [SIZE_ADC_DATA:0]   BASE_EXT  = (SIZE_ADC_DATA+1)'(BASELINE);
  localparam logic [SIZE_ADC_DATA:0]   OUT_MAX   = {1'b0, {SIZE_ADC_DATA{1'b1}}};

  typedef enum logic [1:0] {
    IDLE,
    RISE,
    DECAY
  } state_t;

  state_t                     state, state_nxt;
  logic [W-1:0]               acc, acc_nxt;
  logic [W-1:0]               target, target_nxt;
  logic [W-1:0]               step, step_nxt;
  logic [RISE_SHIFT:0]        rise_cnt, rise_cnt_nxt;
  logic [CW-1:0]              per_cnt;
  logic                       auto_fire;
  logic                       trg;
  logic                       accept;
  logic                       ps_nxt, dr_nxt;

  logic [W-1:0]               amp_ext;
  logic [W:0]                 pile_sum;
  logic [W-1:0]               target_new;
  logic [W:0]                 rise_sum;
  logic [W-1:0]               rise_val;
  logic [SIZE_ADC_DATA-1:0]   acc_int;
  logic [SIZE_ADC_DATA:0]     out_sum;
  logic [SIZE_ADC_DATA-1:0]   out_nxt;

  // Auto-trigger counter only advances while enabled; disabling restarts it from zero.
  always_ff @(posedge clk) begin
    if (reset || !auto_en) begin
      per_cnt <= '0;
    end else if (per_cnt == PER_LAST) begin
      per_cnt <= '0;
    end else begin
      per_cnt <= per_cnt + 1'b1;
    end
  end

  assign auto_fire = auto_en && (per_cnt == PER_LAST);
  assign trg       = trigger | auto_fire;

  // Datapath helpers: one extra bit on sums so clamping sees true overflow.
  always_comb begin
    amp_ext    = {amplitude, {FRAC{1'b0}}};
    pile_sum   = {1'b0, acc} + {1'b0, amp_ext};
    target_new = (pile_sum > {1'b0, ACC_MAX}) ? ACC_MAX : pile_sum[W-1:0];
    rise_sum   = {1'b0, acc} + {1'b0, step};
    rise_val   = (rise_sum > {1'b0, target}) ? target : rise_sum[W-1:0];
    acc_int    = acc[W-1:FRAC];
    out_sum    = BASE_EXT + {1'b0, acc_int};
    out_nxt    = (out_sum > OUT_MAX) ? OUT_MAX[SIZE_ADC_DATA-1:0] : out_sum[SIZE_ADC_DATA-1:0];
  end

  always_comb begin
    state_nxt    = state;
    acc_nxt      = acc;
    target_nxt   = target;
    step_nxt     = step;
    rise_cnt_nxt = rise_cnt;
    ps_nxt       = 1'b0;
    dr_nxt       = 1'b0;
    accept       = 1'b0;

    case (state)
      IDLE: begin
        accept = trg;
      end
      RISE: begin
        dr_nxt       = trg;
        rise_cnt_nxt = rise_cnt + 1'b1;
        if (rise_cnt == RISE_LAST) begin
          acc_nxt   = target;
          state_nxt = DECAY;
        end else begin
          acc_nxt = rise_val;
        end
      end
      DECAY: begin
        if (trg) begin
          accept = 1'b1;
        end else if (acc_int == '0) begin
          acc_nxt   = '0;
          state_nxt = IDLE;
        end else begin
          acc_nxt = acc - (acc >> DECAY_SHIFT);
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    // Pile-up shares the idle accept path: the new rise starts from whatever acc holds.
    if (accept) begin
      state_nxt    = RISE;
      target_nxt   = target_new;
      step_nxt     = amp_ext >> RISE_SHIFT;
      rise_cnt_nxt = '0;
      ps_nxt       = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      acc         <= '0;
      target      <= '0;
      step        <= '0;
      rise_cnt    <= '0;
      output_data <= BASE_EXT[SIZE_ADC_DATA-1:0];
      pulse_start <= 1'b0;
      dropped     <= 1'b0;
    end else begin
      state       <= state_nxt;
      acc         <= acc_nxt;
      target      <= target_nxt;
      step        <= step_nxt;
      rise_cnt    <= rise_cnt_nxt;
      output_data <= out_nxt;
      pulse_start <= ps_nxt;
      dropped     <= dr_nxt;
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_v6_pulse_generator.sv
// Randomized bench for v6_pulse_generator against a trajectory-queue reference model.
module tb_v6_pulse_generator;

  localparam int SIZE    = 12;
  localparam int BASE    = 100;
  localparam int RSHIFT  = 2;
  localparam int DSHIFT  = 4;
  localparam int FR      = 8;
  localparam int PER     = 50;
  localparam int OMAX    = (1 << SIZE) - 1;
  localparam int AMAX    = OMAX << FR;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            trigger = 1'b0;
  logic [SIZE-1:0] amplitude = '0;
  logic            auto_en = 1'b0;
  logic [SIZE-1:0] output_data;
  logic            busy;
  logic            pulse_start;
  logic            dropped;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: acc as a plain integer, pending rise samples precomputed in a queue.
  int m_acc = 0;
  int m_rise_q[$];
  bit m_active = 0;
  int m_cnt = 0;
  int e_out = BASE;
  bit e_ps = 0;
  bit e_dr = 0;

  int max_out;
  int n_ps;
  int n_dr;
  int obs[7];
  int want[7] = '{100, 350, 600, 850, 1100, 1037, 978};

  v6_pulse_generator #(
    .SIZE_ADC_DATA(SIZE),
    .BASELINE(BASE),
    .RISE_SHIFT(RSHIFT),
    .DECAY_SHIFT(DSHIFT),
    .FRAC(FR),
    .PERIOD(PER)
  ) dut (
    .clk(clk),
    .reset(reset),
    .trigger(trigger),
    .amplitude(amplitude),
    .auto_en(auto_en),
    .output_data(output_data),
    .busy(busy),
    .pulse_start(pulse_start),
    .dropped(dropped)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step(input bit t, input int a, input bit ae, input bit r);
    bit fire, trg;
    int step, tgt, v;
    if (r) begin
      m_acc = 0; m_rise_q.delete(); m_active = 0; m_cnt = 0;
      e_out = BASE; e_ps = 0; e_dr = 0;
      return;
    end
    fire  = ae && (m_cnt == PER - 1);
    m_cnt = !ae ? 0 : (m_cnt == PER - 1) ? 0 : m_cnt + 1;
    trg   = t || fire;
    v     = BASE + (m_acc >> FR);
    e_out = (v > OMAX) ? OMAX : v;
    e_ps  = 0;
    e_dr  = 0;
    if (m_rise_q.size() > 0) begin
      e_dr  = trg;
      m_acc = m_rise_q.pop_front();
    end else if (trg) begin
      e_ps     = 1;
      m_active = 1;
      step     = (a << FR) >> RSHIFT;
      tgt      = m_acc + (a << FR);
      if (tgt > AMAX) tgt = AMAX;
      for (int k = 1; k < (1 << RSHIFT); k++)
        m_rise_q.push_back((m_acc + k * step > tgt) ? tgt : m_acc + k * step);
      m_rise_q.push_back(tgt);
    end else if (m_active) begin
      if ((m_acc >> FR) == 0) begin
        m_acc    = 0;
        m_active = 0;
      end else begin
        m_acc = m_acc - m_acc / (1 << DSHIFT);
      end
    end
  endtask

  task automatic cyc(input bit t, input int a, input bit ae, input bit r);
    trigger   = t;
    amplitude = SIZE'(a);
    auto_en   = ae;
    reset     = r;
    @(posedge clk);
    #1;
    model_step(t, a, ae, r);
    check("output_data", int'(output_data), e_out);
    check("busy", int'(busy), int'(m_active));
    check("pulse_start", int'(pulse_start), int'(e_ps));
    check("dropped", int'(dropped), int'(e_dr));
    if (int'(output_data) > max_out) max_out = int'(output_data);
    n_ps += int'(pulse_start);
    n_dr += int'(dropped);
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (busy && n < 400) begin
      cyc(0, 0, 0, 0);
      n++;
    end
    check({tag, "_drain_busy"}, int'(busy), 0);
    check({tag, "_drain_out"}, int'(output_data), BASE);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held, then idle.
    repeat (3) cyc(0, 0, 0, 1);
    n_ps = 0; n_dr = 0;
    repeat (20) cyc(0, 0, 0, 0);
    check("idle_strobes", n_ps + n_dr, 0);

    // Single pulse, amplitude 1000.
    cyc(1, 1000, 0, 0);
    check("s2_pulse_start", int'(pulse_start), 1);
    for (int i = 0; i < 7; i++) begin
      cyc(0, 0, 0, 0);
      obs[i] = int'(output_data);
    end
    for (int i = 0; i < 7; i++) check("s2_shape", obs[i], want[i]);
    drain("s2");

    // Second trigger during the rise is ignored.
    max_out = 0; n_dr = 0;
    cyc(1, 1000, 0, 0);
    cyc(0, 0, 0, 0);
    cyc(1, 3000, 0, 0);
    drain("s3");
    check("s3_dropped_count", n_dr, 1);
    check("s3_peak", max_out, 1100);

    // Pile-up on the first decay cycle, saturating.
    max_out = 0; n_ps = 0;
    cyc(1, 1000, 0, 0);
    repeat (4) cyc(0, 0, 0, 0);
    cyc(1, 4000, 0, 0);
    drain("s4");
    check("s4_pulse_starts", n_ps, 2);
    check("s4_peak", max_out, OMAX);

    // Auto-trigger with PERIOD=50; disable, then re-enable restarts the count.
    n_ps = 0;
    repeat (160) cyc(0, 200, 1, 0);
    check("s5_auto_starts", n_ps, 3);
    repeat (10) cyc(0, 200, 0, 0);
    n_ps = 0;
    repeat (49) cyc(0, 200, 1, 0);
    check("s5_restart_quiet", n_ps, 0);
    cyc(0, 200, 1, 0);
    check("s5_restart_fire", int'(pulse_start), 1);
    drain("s5");

    // Reset in mid-decay, then a clean pulse.
    cyc(1, 1000, 0, 0);
    repeat (8) cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 1);
    check("s6_reset_out", int'(output_data), BASE);
    check("s6_reset_busy", int'(busy), 0);
    cyc(1, 1000, 0, 0);
    for (int i = 0; i < 7; i++) begin
      cyc(0, 0, 0, 0);
      obs[i] = int'(output_data);
    end
    for (int i = 0; i < 7; i++) check("s6_shape", obs[i], want[i]);
    drain("s6");

    // Random traffic including zero amplitude, auto mode and occasional reset.
    begin
      bit ae;
      ae = 0;
      for (int i = 0; i < 3000; i++) begin
        bit t, r;
        int a;
        if ($urandom_range(0, 99) == 0) ae = ~ae;
        t = ($urandom_range(0, 7) == 0);
        r = ($urandom_range(0, 199) == 0);
        case ($urandom_range(0, 3))
          0:       a = 0;
          1:       a = OMAX;
          default: a = $urandom_range(0, OMAX);
        endcase
        cyc(t, a, ae, r);
      end
    end
    drain("rand");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
